// File: rtl/mem_responder_if.sv
// Request/response bundle between the cache (master) and the memory model (slave).
// Requests are implicit: any change on data/addr/wr starts a new access.
interface mem_responder_if;
  logic [31:0] data;
  logic [31:0] addr;
  logic        wr;
  logic        response;
  logic [31:0] out;
  logic [15:0] rd_count;
  logic [15:0] wr_count;

  modport master (output data, addr, wr, input response, out, rd_count, wr_count);
  modport slave  (input data, addr, wr, output response, out, rd_count, wr_count);
endinterface

// File: rtl/mem_responder.sv
// Word-addressed main-memory model: detects requests by input change, waits LATENCY
// cycles, then performs the access and raises response. Keeps saturating traffic counters.
module mem_responder #(
  parameter int DEPTH     = 1024,
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  mem_responder_if.slave  bus
);
  typedef enum logic {IDLE, BUSY} state_e;

  state_e      state_q, state_d;
  logic [31:0] data_q, data_d;
  logic [31:0] addr_q, addr_d;
  logic        wr_q, wr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        resp_q, resp_d;
  logic [31:0] out_q, out_d;
  logic [15:0] rd_cnt_q, rd_cnt_d;
  logic [15:0] wr_cnt_q, wr_cnt_d;
  logic        req, mem_we;

  // Storage survives reset; only the zero image at elaboration initialises it.
  logic [31:0] mem_q [DEPTH] = '{default: '0};

  logic [ADDR_BITS-1:0] idx;
  assign idx = addr_q[ADDR_BITS-1:0];
  assign req = {bus.data, bus.addr, bus.wr} != {data_q, addr_q, wr_q};

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    addr_d   = addr_q;
    wr_d     = wr_q;
    cnt_d    = cnt_q;
    resp_d   = resp_q;
    out_d    = out_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    mem_we   = 1'b0;
    if (req) begin
      // A new request always wins, silently dropping any access still in flight.
      data_d  = bus.data;
      addr_d  = bus.addr;
      wr_d    = bus.wr;
      cnt_d   = 8'(LATENCY - 1);
      resp_d  = 1'b0;
      state_d = BUSY;
    end else if (state_q == BUSY) begin
      if (cnt_q != 8'd0) begin
        cnt_d = cnt_q - 8'd1;
      end else begin
        resp_d  = 1'b1;
        state_d = IDLE;
        if (wr_q) begin
          mem_we   = 1'b1;
          wr_cnt_d = (wr_cnt_q == 16'hFFFF) ? wr_cnt_q : wr_cnt_q + 16'd1;
        end else begin
          out_d    = mem_q[idx];
          rd_cnt_d = (rd_cnt_q == 16'hFFFF) ? rd_cnt_q : rd_cnt_q + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      data_q   <= '0;
      addr_q   <= '0;
      wr_q     <= 1'b0;
      cnt_q    <= '0;
      resp_q   <= 1'b1;
      out_q    <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      addr_q   <= addr_d;
      wr_q     <= wr_d;
      cnt_q    <= cnt_d;
      resp_q   <= resp_d;
      out_q    <= out_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  // mem_we depends on state_q, which reset clears asynchronously, so no write slips through reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx] <= data_q;
  end

  assign bus.response = resp_q;
  assign bus.out      = out_q;
  assign bus.rd_count = rd_cnt_q;
  assign bus.wr_count = wr_cnt_q;
endmodule

// File: tb/tb_mem_responder.sv
// Randomised scoreboard bench for mem_responder: stimulus pushes expected completions,
// a negedge monitor pops and compares them whenever response rises.
module tb_mem_responder;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_responder_if bus();
  mem_responder #(.DEPTH(1024), .ADDR_BITS(10), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct {
    logic [31:0] out;
    int          rd;
    int          wr;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] mdl_mem [1024];
  logic [31:0] mdl_out;
  int          mdl_rd, mdl_wr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: a completed access is just an array read or write plus a clamped count.
  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d, input int extra);
    exp_t e;
    int   n;
    @(negedge clk);
    if ({d, a, w} == {bus.data, bus.addr, bus.wr}) d = d ^ 32'h1;
    bus.wr = w; bus.addr = a; bus.data = d;
    if (w) begin
      mdl_mem[a % 1024] = d;
      mdl_wr = (mdl_wr + 1 > 65535) ? 65535 : mdl_wr + 1;
    end else begin
      mdl_out = mdl_mem[a % 1024];
      mdl_rd  = (mdl_rd + 1 > 65535) ? 65535 : mdl_rd + 1;
    end
    e.out = mdl_out; e.rd = mdl_rd; e.wr = mdl_wr; e.lat = LAT + extra;
    exp_q.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.response !== 1'b1 && n < 100);
    if (n >= 100) chk("req_timeout", 32'(n), 32'd0);
  endtask

  // Monitor: counts low cycles and checks each completion against the queue head.
  logic prev_resp = 1'b1;
  int   low = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_resp = 1'b1;
      low = 0;
    end else begin
      if (!bus.response) low++;
      else if (!prev_resp) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_completion", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("out", bus.out, e.out);
          chk("rd_count", 32'(bus.rd_count), 32'(e.rd));
          chk("wr_count", 32'(bus.wr_count), 32'(e.wr));
          chk("low_cycles", 32'(low), 32'(e.lat));
        end
        low = 0;
      end
      prev_resp = bus.response;
    end
  end

  task automatic reset_model();
    mdl_out = '0; mdl_rd = 0; mdl_wr = 0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_response"}, 32'(bus.response), 32'd1);
    chk({tag, "_out"}, bus.out, 32'd0);
    chk({tag, "_rd_count"}, 32'(bus.rd_count), 32'd0);
    chk({tag, "_wr_count"}, 32'(bus.wr_count), 32'd0);
  endtask

  initial begin
    int n;
    foreach (mdl_mem[i]) mdl_mem[i] = '0;
    reset_model();
    bus.data = '0; bus.addr = '0; bus.wr = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    #2 rst_n = 1'b1;

    // Read of addr 0 / data 0 equals the cleared capture registers: no request.
    repeat (8) begin
      @(negedge clk);
      chk("no_req_response", 32'(bus.response), 32'd1);
    end
    chk("no_req_rd_count", 32'(bus.rd_count), 32'd0);

    do_req(1'b1, 32'd5, 32'hDEADBEEF, 0);
    do_req(1'b0, 32'd5, 32'h0, 0);

    // Abort: write 7 superseded by write 8 two cycles later.
    @(negedge clk);
    bus.wr = 1'b1; bus.addr = 32'd7; bus.data = 32'h11;
    @(negedge clk);
    do_req(1'b1, 32'd8, 32'h11, 2);
    do_req(1'b0, 32'd7, 32'h0, 0);
    do_req(1'b0, 32'd8, 32'h0, 0);

    // Aliasing of upper address bits.
    do_req(1'b1, 32'h0000_0403, 32'hA5, 0);
    do_req(1'b0, 32'd3, 32'h0, 0);

    // Reset in the middle of a write: the write must not commit.
    @(negedge clk);
    bus.wr = 1'b1; bus.addr = 32'd9; bus.data = 32'h77;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    bus.wr = 1'b0; bus.addr = '0; bus.data = '0;
    reset_model();
    repeat (2) @(negedge clk);
    check_reset_vals("midreset");
    #2 rst_n = 1'b1;
    do_req(1'b0, 32'd9, 32'h0, 0);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      a = {$urandom_range(0, 7) == 0 ? 22'($urandom) : 22'd0, 10'($urandom_range(0, 15))};
      do_req(1'($urandom_range(0, 1)), a, $urandom, 0);
    end

    // Saturation: preload counters near the top and confirm they clamp.
    @(negedge clk);
    force dut.rd_cnt_q = 16'hFFFF;
    force dut.wr_cnt_q = 16'hFFFE;
    @(posedge clk);
    #1;
    release dut.rd_cnt_q;
    release dut.wr_cnt_q;
    mdl_rd = 65535; mdl_wr = 65534;
    do_req(1'b0, 32'd5, 32'h0, 0);
    do_req(1'b1, 32'd20, 32'h1234, 0);
    do_req(1'b1, 32'd21, 32'h5678, 0);
    do_req(1'b0, 32'd20, 32'h0, 0);

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
